// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings, default width
// and the counter-width helper. Optional overflow output: SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

   localparam int unsigned SA_WIDTH_DEF = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Bit-slot counter width, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/serial_adder_fa_bit.sv
// Purely combinational one-bit full adder cell used by serial_adder.
module fa_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder around one fa_bit cell, LSB first, one bit per clock.
// Define SERIAL_ADDER_OVF_EN to add the signed overflow output V.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = SA_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             V
`endif
);

   localparam int unsigned CW = cnt_width(WIDTH);

   logic [1:0]       state;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_c;
   logic             last;
   logic             accept;

   fa_bit u_fa (
      .a    (opa[0]),
      .b    (opb[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_c)
   );

   assign last   = (cnt == CW'(WIDTH - 1));
   // DONE accepts a start just like IDLE, giving back-to-back adds.
   assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign busy   = (state == ST_RUN);
   assign done   = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         opa   <= '0;
         opb   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         S     <= '0;
         Cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         V     <= 1'b0;
`endif
      end else if (state == ST_RUN) begin
         opa   <= opa >> 1;
         opb   <= opb >> 1;
         S     <= {fa_s, S[WIDTH-1:1]};
         carry <= fa_c;
         cnt   <= cnt + 1'b1;
         if (last) begin
            Cout  <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
            // carry still holds the carry into bit WIDTH-1 here.
            V     <= carry ^ fa_c;
`endif
            state <= ST_DONE;
         end
      end else if (accept) begin
         opa   <= A;
         opb   <= B;
         carry <= Cin;
         cnt   <= '0;
         state <= ST_RUN;
      end else begin
         // Covers DONE without start and recovery from the unused encoding.
         state <= ST_IDLE;
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8 directed, WIDTH=4 exhaustive).
module tb_serial_adder;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] A, B, S;
   logic       Cin, busy, done, Cout;
   logic       start4;
   logic [3:0] A4, B4, S4;
   logic       Cin4, busy4, done4, Cout4;
`ifdef SERIAL_ADDER_OVF_EN
   logic       V, V4;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   serial_adder #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin),
      .busy(busy), .done(done), .S(S), .Cout(Cout)
`ifdef SERIAL_ADDER_OVF_EN
      , .V(V)
`endif
   );

   serial_adder #(.WIDTH(4)) u4 (
      .clk(clk), .rst(rst), .start(start4), .A(A4), .B(B4), .Cin(Cin4),
      .busy(busy4), .done(done4), .S(S4), .Cout(Cout4)
`ifdef SERIAL_ADDER_OVF_EN
      , .V(V4)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic c);
      A = a; B = b; Cin = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
   endtask

   task automatic wait8(input string tag);
      while (!done && cyc < 40) tick();
      check({tag, " latency"}, cyc, 9);
      check({tag, " done"}, done, 1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
      start4 = 1'b0; A4 = '0; B4 = '0; Cin4 = 1'b0;
      repeat (2) @(negedge clk);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst S", S, 8'h00);
      check("rst Cout", Cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
      check("rst V", V, 0);
`endif
      rst = 1'b0;

      // 0x35 + 0x1C = 0x51
      launch8(8'h35, 8'h1C, 1'b0);
      check("add1 busy", busy, 1);
      wait8("add1");
      check("add1 S", S, 8'h51);
      check("add1 Cout", Cout, 0);
      tick();
      check("add1 done pulse", done, 0);
      check("add1 S held", S, 8'h51);
      check("add1 idle busy", busy, 0);

      // 0xFF + 0x01 + 1 = 0x101
      launch8(8'hFF, 8'h01, 1'b1);
      wait8("add2");
      check("add2 S", S, 8'h01);
      check("add2 Cout", Cout, 1);
`ifdef SERIAL_ADDER_OVF_EN
      check("add2 V", V, 0);
`endif

      // 0x7F + 0x01 = 0x80, signed overflow
      launch8(8'h7F, 8'h01, 1'b0);
      wait8("add3");
      check("add3 S", S, 8'h80);
      check("add3 Cout", Cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
      check("add3 V", V, 1);
`endif

      // start pulsed mid-RUN is ignored: 0x12 + 0x34 = 0x46
      launch8(8'h12, 8'h34, 1'b0);
      tick(); tick();
      A = 8'hAA; B = 8'hAA; Cin = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      wait8("ign");
      check("ign S", S, 8'h46);
      check("ign Cout", Cout, 0);

      // reset in RUN cycle 4 abandons the add
      launch8(8'h55, 8'h66, 1'b1);
      tick(); tick(); tick();
      check("mid busy", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst busy", busy, 0);
      check("midrst done", done, 0);
      check("midrst S", S, 8'h00);
      check("midrst Cout", Cout, 0);
      // 0xC3 + 0x5A = 0x11D
      launch8(8'hC3, 8'h5A, 1'b0);
      wait8("post");
      check("post S", S, 8'h1D);
      check("post Cout", Cout, 1);
`ifdef SERIAL_ADDER_OVF_EN
      check("post V", V, 0);
`endif
      tick();

      // start held through DONE: 0x0F+0x01=0x10, then 0x20+0x22+1=0x43
      A = 8'h0F; B = 8'h01; Cin = 1'b0; start = 1'b1;
      tick();
      cyc = 1;
      A = 8'h20; B = 8'h22; Cin = 1'b1;
      wait8("hold1");
      check("hold1 S", S, 8'h10);
      check("hold1 Cout", Cout, 0);
      tick();
      check("hold2 busy", busy, 1);
      check("hold2 done", done, 0);
      start = 1'b0;
      cyc = 1;
      wait8("hold2");
      check("hold2 S", S, 8'h43);
      check("hold2 Cout", Cout, 0);

      // exhaustive WIDTH=4, back-to-back
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int c = 0; c < 2; c++) begin
               int n;
               A4 = a[3:0]; B4 = b[3:0]; Cin4 = c[0]; start4 = 1'b1;
               @(negedge clk);
               start4 = 1'b0;
               n = 1;
               while (!done4 && n < 20) begin
                  @(negedge clk);
                  n++;
               end
               check("exh latency", n, 5);
               check($sformatf("exh %0d+%0d+%0d", a, b, c), {27'd0, Cout4, S4}, 32'(a + b + c));
`ifdef SERIAL_ADDER_OVF_EN
               begin
                  int sa, sb, ss;
                  sa = (a >= 8) ? a - 16 : a;
                  sb = (b >= 8) ? b - 16 : b;
                  ss = sa + sb + c;
                  check("exh V", V4, (ss > 7 || ss < -8) ? 1 : 0);
               end
`endif
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
